tern_mvm_stream: RTL and testbench

Parametrised ternary matrix-vector multiplier, the next generation of the tile's ternary MAC. Accepts a signed input vector LANES elements per beat over a valid/ready stream and accumulates against a flat 2-bit ternary weight bus. It then streams the OUT_LEN column results out one per beat, also valid/ready. Supports runtime row/column trimming, batches of back-to-back vectors, and stalling via en.

---
 rtl/tern_mvm_stream.sv | 199 +++++++++++++++++++
 tb/tb_tern_mvm_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tern_mvm_stream.sv
// tern_mvm_stream: streaming ternary matrix-vector multiplier.
// Accepts LANES signed elements per beat, accumulates them against a flat
// 2-bit ternary weight bus (01=+1, 11=-1, 00/10=0), then streams the active
// column results out one per beat. Supports runtime row/column trimming,
// batches of vectors per job, and a global freeze via en.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              global enable; low freezes all state
//   start           job start pulse (honoured only when idle)
//   rows_cfg        active beats per vector minus 1
//   cols_cfg        active columns minus 1
//   batch_cfg       vectors per job minus 1
//   w               weight (r,c) at w[2*(r*OUT_LEN+c)+:2]
//   vec_in/valid/ready   input beat stream
//   vec_out/out_valid/out_ready   column result stream
//   busy, done      job in progress / end-of-job pulse
//
// Build option: define TERN_SAT_EN to saturate results to BIT_WIDTH;
// otherwise results are the low BIT_WIDTH bits of the accumulator.
module tern_mvm_stream #(
    parameter int unsigned  IN_LEN    = 16,
    parameter int unsigned  OUT_LEN   = 8,
    parameter int unsigned  BIT_WIDTH = 8,
    parameter int unsigned  LANES     = 2,
    localparam int unsigned ACC_WIDTH = BIT_WIDTH + $clog2(IN_LEN) + 1,
    localparam int unsigned BEATS     = IN_LEN / LANES,
    localparam int unsigned ROWS_W    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned COLS_W    = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic [ROWS_W-1:0]            rows_cfg,
    input  logic [COLS_W-1:0]            cols_cfg,
    input  logic [3:0]                   batch_cfg,
    input  logic [2*IN_LEN*OUT_LEN-1:0]  w,
    input  logic [LANES*BIT_WIDTH-1:0]   vec_in,
    input  logic                         vec_valid,
    output logic                         vec_ready,
    output logic [BIT_WIDTH-1:0]         vec_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

`ifdef TERN_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (BIT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    state_e                      state_q, state_d;
    logic [ROWS_W-1:0]           beat_q, beat_d;
    logic [ROWS_W-1:0]           rows_q, rows_d;
    logic [COLS_W-1:0]           col_q, col_d;
    logic [COLS_W-1:0]           cols_q, cols_d;
    logic [3:0]                  rem_q, rem_d;
    logic signed [ACC_WIDTH-1:0] acc_q   [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] acc_d   [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] acc_sum [OUT_LEN];
    logic [BIT_WIDTH-1:0]        vec_out_q, vec_out_d;
    logic                        done_q, done_d;

    // Signed ternary product, formed at accumulator width so -(-2^(BW-1)) does not wrap.
    function automatic logic signed [ACC_WIDTH-1:0] tern(input logic [1:0] wt,
                                                         input logic [BIT_WIDTH-1:0] x);
        logic signed [ACC_WIDTH-1:0] xe;
        xe = {{(ACC_WIDTH - BIT_WIDTH){x[BIT_WIDTH-1]}}, x};
        if (wt == 2'b01) begin
            return xe;
        end else if (wt == 2'b11) begin
            return -xe;
        end
        return '0;
    endfunction

    // Accumulator to output-width conversion.
    function automatic logic [BIT_WIDTH-1:0] fmt(input logic signed [ACC_WIDTH-1:0] a);
`ifdef TERN_SAT_EN
        if (a > SAT_MAX) begin
            return SAT_MAX[BIT_WIDTH-1:0];
        end else if (a < SAT_MIN) begin
            return SAT_MIN[BIT_WIDTH-1:0];
        end
        return a[BIT_WIDTH-1:0];
`else
        return a[BIT_WIDTH-1:0];
`endif
    endfunction

    // Per-column sum including the beat currently on vec_in.
    always_comb begin
        for (int c = 0; c < int'(OUT_LEN); c++) begin
            acc_sum[c] = acc_q[c];
            for (int k = 0; k < int'(LANES); k++) begin
                int widx;
                widx = 2 * ((int'(beat_q) * int'(LANES) + k) * int'(OUT_LEN) + c);
                acc_sum[c] = acc_sum[c] + tern(w[widx +: 2], vec_in[k*BIT_WIDTH +: BIT_WIDTH]);
            end
        end
    end

    // Next-state logic; every update is qualified by en.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rows_d    = rows_q;
        col_d     = col_q;
        cols_d    = cols_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        vec_out_d = vec_out_q;
        done_d    = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        rows_d  = rows_cfg;
                        cols_d  = cols_cfg;
                        rem_d   = batch_cfg;
                        beat_d  = '0;
                        col_d   = '0;
                        for (int c = 0; c < int'(OUT_LEN); c++) acc_d[c] = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (vec_valid) begin
                        for (int c = 0; c < int'(OUT_LEN); c++) begin
                            if (COLS_W'(c) <= cols_q) acc_d[c] = acc_sum[c];
                        end
                        beat_d = beat_q + ROWS_W'(1);
                        if (beat_q == rows_q) begin
                            beat_d    = '0;
                            vec_out_d = fmt(acc_sum[0]);
                            state_d   = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (col_q == cols_q) begin
                            col_d = '0;
                            if (rem_q != 4'd0) begin
                                rem_d   = rem_q - 4'd1;
                                for (int c = 0; c < int'(OUT_LEN); c++) acc_d[c] = '0;
                                state_d = ACCUM;
                            end else begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            col_d     = col_q + COLS_W'(1);
                            vec_out_d = fmt(acc_q[col_d]);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            rows_q    <= '0;
            col_q     <= '0;
            cols_q    <= '0;
            rem_q     <= '0;
            vec_out_q <= '0;
            done_q    <= 1'b0;
            for (int c = 0; c < int'(OUT_LEN); c++) acc_q[c] <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rows_q    <= rows_d;
            col_q     <= col_d;
            cols_q    <= cols_d;
            rem_q     <= rem_d;
            vec_out_q <= vec_out_d;
            done_q    <= done_d;
            for (int c = 0; c < int'(OUT_LEN); c++) acc_q[c] <= acc_d[c];
        end
    end

    // Handshake outputs are gated by en so a frozen block never offers or accepts data.
    assign vec_ready = (state_q == ACCUM) & en;
    assign out_valid = (state_q == DRAIN) & en;
    assign vec_out   = vec_out_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q & en;

endmodule

// File: tb/tb_tern_mvm_stream.sv
`timescale 1ns/1ps
module tb_tern_mvm_stream;

    localparam int IN_LEN    = 16;
    localparam int OUT_LEN   = 8;
    localparam int BIT_WIDTH = 8;
    localparam int LANES     = 2;
    localparam int OUT_MAX   = (2 ** (BIT_WIDTH - 1)) - 1;
    localparam int OUT_MIN   = -(2 ** (BIT_WIDTH - 1));

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        en;
    logic                        start;
    logic [2:0]                  rows_cfg;
    logic [2:0]                  cols_cfg;
    logic [3:0]                  batch_cfg;
    logic [2*IN_LEN*OUT_LEN-1:0] w;
    logic [LANES*BIT_WIDTH-1:0]  vec_in;
    logic                        vec_valid;
    logic                        vec_ready;
    logic [BIT_WIDTH-1:0]        vec_out;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    logic                        done;

    tern_mvm_stream dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .rows_cfg  (rows_cfg),
        .cols_cfg  (cols_cfg),
        .batch_cfg (batch_cfg),
        .w         (w),
        .vec_in    (vec_in),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_out   (vec_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int col_seen = 0;
    int done_cnt = 0;
    bit rnd_mode = 1'b0;
    int wmat [IN_LEN][OUT_LEN];
    int vecs [16][IN_LEN];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain dot product of weight column and vector, then output formatting.
    function automatic int model_col(input int v, input int c, input int rows);
        int s;
        s = 0;
        for (int r = 0; r < (rows + 1) * LANES; r++) s += wmat[r][c] * vecs[v][r];
        return s;
    endfunction

    function automatic int fmt_model(input int a);
        int m;
`ifdef TERN_SAT_EN
        m = (a > OUT_MAX) ? OUT_MAX : ((a < OUT_MIN) ? OUT_MIN : a);
`else
        m = a % (2 ** BIT_WIDTH);
        if (m < 0) m += 2 ** BIT_WIDTH;
        if (m > OUT_MAX) m -= 2 ** BIT_WIDTH;
`endif
        return m;
    endfunction

    task automatic set_w(input bit alt_zero);
        for (int r = 0; r < IN_LEN; r++) begin
            for (int c = 0; c < OUT_LEN; c++) begin
                if (wmat[r][c] > 0)      w[2*(r*OUT_LEN+c) +: 2] = 2'b01;
                else if (wmat[r][c] < 0) w[2*(r*OUT_LEN+c) +: 2] = 2'b11;
                else                     w[2*(r*OUT_LEN+c) +: 2] = (alt_zero && ((r + c) % 2 == 1)) ? 2'b10 : 2'b00;
            end
        end
    endtask

    task automatic fill(input int wval, input int xval);
        for (int r = 0; r < IN_LEN; r++) begin
            for (int c = 0; c < OUT_LEN; c++) wmat[r][c] = wval;
            for (int v = 0; v < 16; v++) vecs[v][r] = xval;
        end
    endtask

    task automatic load_beat(input int v, input int b);
        for (int k = 0; k < LANES; k++) vec_in[k*BIT_WIDTH +: BIT_WIDTH] = 8'(vecs[v][b*LANES+k]);
    endtask

    // Drives one vector's beats; returns aligned just after a rising edge.
    task automatic drive_vector(input int v, input int rows, input bit en_stall, input bit stray);
        for (int b = 0; b <= rows; b++) begin
            bit accepted;
            int guard;
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 200) begin
                if (en_stall && b == 3 && guard == 0) begin
                    load_beat(v, b);
                    vec_valid = 1'b1;
                    en        = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        check("stall_accum_ready", int'(vec_ready), 0);
                        @(posedge clk); #1;
                    end
                    en = 1'b1;
                end
                if (stray && b == 1 && guard == 0) start = 1'b1;
                vec_valid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (vec_valid) load_beat(v, b);
                else vec_in = 16'($urandom);
                @(negedge clk);
                accepted = vec_valid && vec_ready && en;
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
            end
            check("beat_accepted", int'(accepted), 1);
        end
        vec_valid = 1'b0;
        @(negedge clk);
        check("out_valid_latency", int'(out_valid), 1);
        if (en_stall) begin
            @(posedge clk); #1;
            en = 1'b0;
            repeat (5) begin
                @(negedge clk);
                check("stall_drain_valid", int'(out_valid), 0);
                @(posedge clk); #1;
            end
            en = 1'b1;
        end else if (stray) begin
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start(input int rows, input int cols, input int batch);
        rows_cfg  = 3'(rows);
        cols_cfg  = 3'(cols);
        batch_cfg = 4'(batch);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        rows_cfg  = 3'($urandom);
        cols_cfg  = 3'($urandom);
        batch_cfg = 4'($urandom);
    endtask

    task automatic run_job(input int rows, input int cols, input int batch,
                           input bit en_stall, input bit stray);
        int d0;
        int g;
        d0 = done_cnt;
        pulse_start(rows, cols, batch);
        for (int v = 0; v <= batch; v++) begin
            for (int c = 0; c <= cols; c++) exp_q.push_back(fmt_model(model_col(v, c, rows)));
            drive_vector(v, rows, en_stall && v == 0, stray);
        end
        g = 0;
        while (done_cnt == d0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("busy_idle", int'(busy), 0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_vec_ready"}, int'(vec_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_vec_out"},   int'(vec_out),   0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_done"},      int'(done),      0);
        @(posedge clk); #1;
    endtask

    // Consumer: ready always high, or random when rnd_mode is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: checks every emitted column and output-stream rules each cycle.
    initial begin
        bit hold;
        int hold_val;
        hold = 1'b0;
        hold_val = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                check("ready_valid_exclusive", int'(vec_ready && out_valid), 0);
                if (hold && out_valid) check("vec_out_stable", int'($signed(vec_out)), hold_val);
                if (out_valid && out_ready && en) begin
                    col_seen++;
                    check("column_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("column_value", int'($signed(vec_out)), exp_q.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    check("busy_low_at_done", int'(busy), 0);
                    check("done_after_last_col", exp_q.size(), 0);
                end
                hold     = out_valid && !out_ready;
                hold_val = int'($signed(vec_out));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int g;
        rst = 1'b1; en = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_in = '0;
        rows_cfg = '0; cols_cfg = '0; batch_cfg = '0; w = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        // 1: all +1 weights, all-ones vector.
        fill(1, 1);
        set_w(1'b0);
        check("pin_s1_col", fmt_model(model_col(0, 0, 7)), 16);
        run_job(7, 7, 0, 1'b0, 1'b0);

        // 2: alternating signs in column 0, ramp input.
        fill(0, 0);
        for (int r = 0; r < IN_LEN; r++) begin
            wmat[r][0] = (r % 2 == 0) ? 1 : -1;
            vecs[0][r] = r;
        end
        set_w(1'b1);
        check("pin_s2_col0", fmt_model(model_col(0, 0, 7)), -8);
        check("pin_s2_col5", fmt_model(model_col(0, 5, 7)), 0);
        run_job(7, 7, 0, 1'b0, 1'b0);

        // 3: accumulation beyond output range.
        fill(1, 100);
        set_w(1'b0);
`ifdef TERN_SAT_EN
        check("pin_s3_col", fmt_model(model_col(0, 3, 7)), 127);
`else
        check("pin_s3_col", fmt_model(model_col(0, 3, 7)), 64);
`endif
        run_job(7, 7, 0, 1'b0, 1'b0);

        // 4: trimmed rows/cols, batch of 3, stray start pulses.
        fill(1, 3);
        set_w(1'b0);
        check("pin_s4_col", fmt_model(model_col(2, 2, 1)), 12);
        run_job(1, 2, 2, 1'b0, 1'b1);

        // 5: random backpressure, then en stalls in ACCUM and DRAIN.
        fill(1, 1);
        set_w(1'b0);
        rnd_mode = 1'b1;
        run_job(7, 7, 0, 1'b0, 1'b0);
        rnd_mode = 1'b0;
        run_job(7, 7, 0, 1'b1, 1'b0);

        // 6: reset in DRAIN after three columns, then a clean rerun.
        c0 = col_seen;
        pulse_start(7, 7, 0);
        for (int c = 0; c < OUT_LEN; c++) exp_q.push_back(fmt_model(model_col(0, c, 7)));
        drive_vector(0, 7, 1'b0, 1'b0);
        g = 0;
        while (col_seen - c0 < 3 && g < 100) begin
            @(negedge clk); #1;
            g++;
        end
        check("cols_before_reset", col_seen - c0, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check_idle("mid_reset");
        run_job(7, 7, 0, 1'b0, 1'b0);

        // 7: single-beat, single-column, 16-vector batch with most-negative input.
        fill(0, 0);
        wmat[0][0] = -1;
        wmat[1][0] = 1;
        for (int v = 0; v < 16; v++) begin
            vecs[v][0] = -128 + v * 9;
            vecs[v][1] = 100 - v * 13;
        end
        set_w(1'b1);
`ifdef TERN_SAT_EN
        check("pin_s7_v0", fmt_model(model_col(0, 0, 0)), 127);
`else
        check("pin_s7_v0", fmt_model(model_col(0, 0, 0)), -28);
`endif
        run_job(0, 0, 15, 1'b0, 1'b0);

        // 8: random mixed weights and data with random handshakes.
        for (int r = 0; r < IN_LEN; r++) begin
            for (int c = 0; c < OUT_LEN; c++) wmat[r][c] = int'($urandom_range(0, 2)) - 1;
            for (int v = 0; v < 2; v++) vecs[v][r] = int'($urandom_range(0, 255)) - 128;
        end
        set_w(1'b1);
        rnd_mode = 1'b1;
        run_job(5, 4, 1, 1'b0, 1'b0);
        rnd_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
